// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encodings, grant encodings and timeout default for mem_arbiter
package mem_arb_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY_I = 2'd1;
  localparam state_t BUSY_D = 2'd2;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
  localparam int TIMEOUT_DEF = 15;
  function automatic logic [3:0] limit_of(input int t);
    return 4'(t);
  endfunction
endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// wait_timer: counts stalled memory cycles and flags the last one allowed before abort
module wait_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [3:0] limit,
  output logic       expired
);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    cnt <= (reset | clear) ? 4'd0 : enable ? cnt + 4'd1 : cnt;
  assign expired = cnt == limit - 4'd1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between fetch and data ports
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);
  state_t state;
  logic last_gnt, we_q, expired;
  logic [31:0] addr_q, wdata_q;
  logic busy, req_i, req_d, grant, gnt_d, done, tmo, end_i, end_d;
  // a requester whose ready pulse is showing is masked so it cannot be granted twice
  assign req_i = if_req & ~if_ready;
  assign req_d = d_req & ~d_ready;
  assign busy = state != IDLE;
  assign grant = ~busy & (req_i | req_d);
  assign gnt_d = req_d & (~req_i | (last_gnt == GNT_I));
  assign done = busy & m_ack;
  assign tmo = busy & ~m_ack & expired;
  assign end_i = (done | tmo) & (state == BUSY_I);
  assign end_d = (done | tmo) & (state == BUSY_D);
  wait_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant),
    .enable  (busy & ~m_ack),
    .limit   (limit_of(TIMEOUT)),
    .expired (expired)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= GNT_D;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      if_ready <= 1'b0;
      if_rdata <= '0;
      if_err   <= 1'b0;
      d_ready  <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      state <= grant ? (gnt_d ? BUSY_D : BUSY_I) : (done | tmo) ? IDLE : state;
      if (grant) begin
        last_gnt <= gnt_d ? GNT_D : GNT_I;
        we_q     <= gnt_d & d_we;
        addr_q   <= gnt_d ? d_addr : if_addr;
        wdata_q  <= gnt_d ? d_wdata : '0;
      end
      if_ready <= end_i;
      if_rdata <= (end_i & m_ack) ? m_rdata : '0;
      if_err   <= end_i & ~m_ack;
      d_ready  <= end_d;
      d_rdata  <= (end_d & m_ack) ? m_rdata : '0;
      d_err    <= end_d & ~m_ack;
    end
  end
  assign m_req = busy;
  assign m_we = we_q & (state == BUSY_D);
  assign m_addr = addr_q;
  assign m_wdata = wdata_q;
endmodule
